// File: rtl/wb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_spi_master
// Description : Wishbone-controlled SPI master, mode 0, MSB first, 1-4 bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_spi_master #(
    parameter logic [7:0] DEFAULT_DIV = 8'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        sck,
    output logic        ssn,
    output logic        mosi,
    input  logic        miso,
    output logic        o_irq
);

    localparam logic [1:0] c_ADR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADR_STATUS = 2'd1;
    localparam logic [1:0] c_ADR_TXDATA = 2'd2;
    localparam logic [1:0] c_ADR_RXDATA = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_ss_assert;
    logic        r_irq_en;
    logic [1:0]  r_len;
    logic [7:0]  r_clk_div;
    logic        r_rx_valid;
    logic        r_overrun;
    logic [31:0] r_rx_data;
    logic [31:0] r_shift_tx;
    logic [31:0] r_shift_rx;
    logic [7:0]  r_div_cnt;
    logic [5:0]  r_bit_cnt;
    logic        r_sck;
    logic        r_ssn;

    logic        w_acc;
    logic        w_wr;
    logic        w_rx_read;
    logic        w_busy;
    logic [31:0] w_tx_aligned;
    logic [31:0] w_rd_mux;

    // The ~r_ack term keeps a held strobe from being acknowledged twice in a row.
    assign w_acc     = i_wb_cyc & i_wb_stb & ~r_ack;
    assign w_wr      = w_acc & i_wb_we;
    assign w_rx_read = w_acc & ~i_wb_we & (i_wb_adr == c_ADR_RXDATA);
    assign w_busy    = (r_state == ST_SHIFT);

    // Left-align the active bytes so the first bit to send is always bit 31.
    assign w_tx_aligned = i_wb_dat << {~r_len, 3'b000};

    always_comb begin
        w_rd_mux = 32'd0;
        case (i_wb_adr)
            c_ADR_CTRL:   w_rd_mux = {8'd0, r_clk_div, 6'd0, r_len, 6'd0, r_irq_en, r_ss_assert};
            c_ADR_STATUS: w_rd_mux = {29'd0, r_overrun, r_rx_valid, w_busy};
            c_ADR_RXDATA: w_rd_mux = r_rx_data;
            default:      w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ack       <= 1'b0;
            r_dat       <= 32'd0;
            r_ss_assert <= 1'b0;
            r_irq_en    <= 1'b0;
            r_len       <= 2'd3;
            r_clk_div   <= DEFAULT_DIV;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_rx_data   <= 32'd0;
            r_shift_tx  <= 32'd0;
            r_shift_rx  <= 32'd0;
            r_div_cnt   <= 8'd0;
            r_bit_cnt   <= 6'd0;
            r_sck       <= 1'b0;
            r_ssn       <= 1'b1;
        end else begin
            r_ack <= w_acc;
            if (w_acc) begin
                r_dat <= w_rd_mux;
            end

            if (w_rx_read) begin
                r_rx_valid <= 1'b0;
            end

            if (w_wr) begin
                case (i_wb_adr)
                    c_ADR_CTRL: begin
                        if (w_busy) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_ss_assert <= i_wb_dat[0];
                            r_irq_en    <= i_wb_dat[1];
                            r_len       <= i_wb_dat[9:8];
                            r_clk_div   <= i_wb_dat[23:16];
                            r_ssn       <= ~i_wb_dat[0];
                        end
                    end
                    c_ADR_STATUS: begin
                        if (i_wb_dat[2]) begin
                            r_overrun <= 1'b0;
                        end
                    end
                    c_ADR_TXDATA: begin
                        if (w_busy) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_state    <= ST_SHIFT;
                            r_div_cnt  <= r_clk_div;
                            r_sck      <= 1'b0;
                            r_bit_cnt  <= {({1'b0, r_len} + 3'd1), 3'b000};
                            r_shift_tx <= w_tx_aligned;
                            r_shift_rx <= 32'd0;
                        end
                    end
                    default: ;
                endcase
            end

            // Completion is evaluated last so its rx_valid/overrun updates win.
            if (w_busy) begin
                if (r_div_cnt != 8'd0) begin
                    r_div_cnt <= r_div_cnt - 8'd1;
                end else begin
                    r_div_cnt <= r_clk_div;
                    r_sck     <= ~r_sck;
                    if (!r_sck) begin
                        r_shift_rx <= {r_shift_rx[30:0], miso};
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 6'd1;
                        if (r_bit_cnt == 6'd1) begin
                            r_state    <= ST_IDLE;
                            r_rx_data  <= r_shift_rx;
                            r_rx_valid <= 1'b1;
                            if (r_rx_valid) begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_shift_tx <= {r_shift_tx[30:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

    assign o_wb_ack = r_ack;
    assign o_wb_dat = r_dat;
    assign sck      = r_sck;
    assign ssn      = r_ssn;
    assign mosi     = r_shift_tx[31];
    assign o_irq    = r_rx_valid & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_wb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_spi_master
// Description : Scoreboard bench for wb_spi_master with loopback and SPI slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [1:0]  wb_adr = 2'd0;
    logic [31:0] wb_dat_w = 32'd0;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        sck;
    logic        ssn;
    logic        mosi;
    logic        miso;
    logic        irq;

    logic        loop_en = 1'b0;
    logic        s_miso = 1'b0;
    assign miso = loop_en ? mosi : s_miso;

    always #5 clk = ~clk;

    wb_spi_master #(.DEFAULT_DIV(8'd3)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_wb_cyc (wb_cyc),
        .i_wb_stb (wb_stb),
        .i_wb_we  (wb_we),
        .i_wb_adr (wb_adr),
        .i_wb_dat (wb_dat_w),
        .o_wb_dat (wb_dat_r),
        .o_wb_ack (wb_ack),
        .sck      (sck),
        .ssn      (ssn),
        .mosi     (mosi),
        .miso     (miso),
        .o_irq    (irq)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // Free-running cycle count and SPI line monitors, sampled mid-cycle.
    int   cyc_n = 0;
    int   rises = 0;
    int   ssn_rises = 0;
    int   last_fall = 0;
    logic prev_sck = 1'b0;
    logic prev_ssn = 1'b1;
    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) begin
        if (!prev_sck && sck) rises++;
        if (prev_sck && !sck) last_fall = cyc_n;
        if (!prev_ssn && ssn) ssn_rises++;
        prev_sck = sck;
        prev_ssn = ssn;
    end

    // Peripheral model: 0x02 write, 0x03 read, 0x05 status (id 0xde, status 0xad).
    logic [31:0] mem [0:2047];
    logic [63:0] s_sh = 64'd0;
    logic [7:0]  s_cmd = 8'd0;
    logic [23:0] s_addr = 24'd0;
    int          s_cnt = 0;
    logic [15:0] s_stat = 16'hdead;
    logic [31:0] s_word;
    always @(negedge ssn) begin
        s_cnt  = 0;
        s_miso = 1'b0;
    end
    always @(posedge sck) begin
        if (!ssn) begin
            s_sh = {s_sh[62:0], mosi};
            s_cnt++;
            if (s_cnt == 8)  s_cmd = s_sh[7:0];
            if (s_cnt == 32) s_addr = s_sh[23:0];
            if (s_cnt == 64 && s_cmd == 8'h02) mem[s_addr[10:0]] = s_sh[31:0];
        end
    end
    always @(negedge sck) begin
        if (!ssn) begin
            s_miso = 1'b0;
            if (s_cmd == 8'h05 && s_cnt >= 8 && s_cnt < 24) begin
                s_miso = s_stat[23 - s_cnt];
            end else if (s_cmd == 8'h03 && s_cnt >= 32 && s_cnt < 64) begin
                s_word = mem[s_addr[10:0]];
                s_miso = s_word[63 - s_cnt];
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int n;
        n = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = wdat;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!wb_ack && n < 20);
        if (!wb_ack) begin
            checks++; failures++;
            $display("FAIL wb_ack_timeout adr=%0d got no ack, required ack", adr);
        end
        rdat = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        int n;
        n = 0;
        do begin
            wb_xfer(1'b0, 2'd1, 32'd0, st);
            n++;
        end while (st[0] && n < 500);
        if (st[0]) begin
            checks++; failures++;
            $display("FAIL busy_timeout status=%h required busy=0", st);
        end
    endtask

    // One framed transfer with ss held; expected RX goes through the scoreboard.
    task automatic spi_xfer(input logic [7:0] div, input logic [1:0] len,
                            input logic [31:0] tx, input logic [31:0] exp_rx);
        logic [31:0] rd;
        logic [31:0] want;
        wb_write(2'd0, {8'd0, div, 6'd0, len, 6'd0, 1'b0, 1'b1});
        exp_q.push_back(exp_rx);
        wb_write(2'd2, tx);
        wait_idle();
        wb_xfer(1'b0, 2'd3, 32'd0, rd);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL spi_rx scoreboard empty got=%h", rd);
        end else begin
            want = exp_q.pop_front();
            if (rd !== want) begin
                failures++;
                $display("FAIL spi_rx tx=%h got=%h required=%h", tx, rd, want);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (sck !== 1'b0)  begin failures++; $display("FAIL rst_sck got=%b required=0", sck); end
        checks++; if (ssn !== 1'b1)  begin failures++; $display("FAIL rst_ssn got=%b required=1", ssn); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b required=0", mosi); end
        checks++; if (wb_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b required=0", wb_ack); end
        checks++; if (irq !== 1'b0)  begin failures++; $display("FAIL rst_irq got=%b required=0", irq); end
        @(negedge clk);
        rst = 1'b0;
        wb_xfer(1'b0, 2'd0, 32'd0, rd);
        checks++; if (rd !== 32'h0003_0300) begin failures++; $display("FAIL rst_ctrl got=%h required=00030300", rd); end
        wb_xfer(1'b0, 2'd1, 32'd0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_status got=%h required=0", rd); end
    endtask

    task automatic test_loopback();
        logic [31:0] rd;
        logic [31:0] want;
        int r0;
        int base;
        loop_en = 1'b1;
        wb_write(2'd0, 32'h0000_0302);
        r0 = rises;
        exp_q.push_back(32'hdead_beef);
        wb_write(2'd2, 32'hdead_beef);
        base = cyc_n;
        repeat (63) @(negedge clk);
        wb_xfer(1'b0, 2'd1, 32'd0, rd);
        checks++; if (rd[0] !== 1'b1) begin failures++; $display("FAIL lb_busy_last_cycle got=%b required=1", rd[0]); end
        wb_xfer(1'b0, 2'd1, 32'd0, rd);
        checks++; if (rd !== 32'h2) begin failures++; $display("FAIL lb_status_done got=%h required=2", rd); end
        checks++; if (rises - r0 !== 32) begin failures++; $display("FAIL lb_sck_pulses got=%0d required=32", rises - r0); end
        checks++; if (last_fall - base !== 64) begin failures++; $display("FAIL lb_busy_len got=%0d required=64", last_fall - base); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL lb_irq_set got=%b required=1", irq); end
        wb_xfer(1'b0, 2'd3, 32'd0, rd);
        want = exp_q.pop_front();
        checks++; if (rd !== want) begin failures++; $display("FAIL lb_rxdata got=%h required=%h", rd, want); end
        wb_xfer(1'b0, 2'd1, 32'd0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL lb_rx_valid_clear got=%h required=0", rd); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL lb_irq_clear got=%b required=0", irq); end
    endtask

    task automatic test_status_frame();
        int r0;
        loop_en = 1'b0;
        spi_xfer(8'd0, 2'd0, 32'h05, 32'h0);
        r0 = ssn_rises;
        spi_xfer(8'd0, 2'd1, 32'h0, 32'h0000_dead);
        checks++; if (ssn !== 1'b0 || ssn_rises !== r0) begin
            failures++; $display("FAIL sf_ssn_low ssn=%b rises=%0d required ssn=0 rises=%0d", ssn, ssn_rises, r0);
        end
        wb_write(2'd0, 32'h0);
        checks++; if (ssn !== 1'b1) begin failures++; $display("FAIL sf_ssn_release got=%b required=1", ssn); end
    endtask

    task automatic test_write_read();
        loop_en = 1'b0;
        spi_xfer(8'd1, 2'd0, 32'h02, 32'h0);
        spi_xfer(8'd1, 2'd2, 32'h0007fe, 32'h0);
        spi_xfer(8'd1, 2'd3, 32'hfeed_f00d, 32'h0);
        wb_write(2'd0, 32'h0);
        spi_xfer(8'd1, 2'd0, 32'h03, 32'h0);
        spi_xfer(8'd1, 2'd2, 32'h0007fe, 32'h0);
        spi_xfer(8'd1, 2'd3, 32'h0, 32'hfeed_f00d);
        wb_write(2'd0, 32'h0);
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        logic [31:0] want;
        int r0;
        loop_en = 1'b1;
        wb_write(2'd0, 32'h0003_0300);
        r0 = rises;
        exp_q.push_back(32'h1234_5678);
        wb_write(2'd2, 32'h1234_5678);
        wb_write(2'd2, 32'hffff_ffff);
        wb_write(2'd0, 32'h0000_0001);
        checks++; if (ssn !== 1'b1) begin failures++; $display("FAIL ov_ctrl_dropped ssn=%b required=1", ssn); end
        wait_idle();
        checks++; if (rises - r0 !== 32) begin failures++; $display("FAIL ov_sck_pulses got=%0d required=32", rises - r0); end
        wb_xfer(1'b0, 2'd1, 32'd0, rd);
        checks++; if (rd !== 32'h6) begin failures++; $display("FAIL ov_status got=%h required=6", rd); end
        wb_xfer(1'b0, 2'd0, 32'd0, rd);
        checks++; if (rd !== 32'h0003_0300) begin failures++; $display("FAIL ov_ctrl_kept got=%h required=00030300", rd); end
        wb_xfer(1'b0, 2'd3, 32'd0, rd);
        want = exp_q.pop_front();
        checks++; if (rd !== want) begin failures++; $display("FAIL ov_rxdata got=%h required=%h", rd, want); end
        wb_write(2'd1, 32'h4);
        wb_xfer(1'b0, 2'd1, 32'd0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL ov_clear got=%h required=0", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int r0;
        int n;
        loop_en = 1'b1;
        wb_write(2'd0, 32'h0003_0301);
        r0 = rises;
        wb_write(2'd2, 32'ha5a5_a5a5);
        n = 0;
        while (rises - r0 < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rises - r0 < 5) begin failures++; $display("FAIL mid_sck_rises got=%0d required=5", rises - r0); end
        #2 rst = 1'b1;
        #1;
        checks++; if (sck !== 1'b0) begin failures++; $display("FAIL mid_sck got=%b required=0", sck); end
        checks++; if (ssn !== 1'b1) begin failures++; $display("FAIL mid_ssn got=%b required=1", ssn); end
        @(negedge clk);
        rst = 1'b0;
        wb_xfer(1'b0, 2'd1, 32'd0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_status got=%h required=0", rd); end
        wb_xfer(1'b0, 2'd0, 32'd0, rd);
        checks++; if (rd !== 32'h0003_0300) begin failures++; $display("FAIL mid_ctrl got=%h required=00030300", rd); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_loopback();
        test_status_frame();
        test_write_read();
        test_overrun();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d entries required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
